// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Single-cycle logic/arith ops; a 32-iteration
// shift-add multiplier for MUL. One operation in flight at a time.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous reset, active low
//   start_i     operation request, sampled only while idle
//   ALUCtrl_i   operation code (AND/OR/ADD/SUB/SLT/NOR/MUL)
//   src1_i      operand A
//   src2_i      operand B
//   busy_o      operation in progress or completing
//   done_o      one-cycle completion pulse
//   result_o    registered result
//   zero_o      registered result==0 flag
//   overflow_o  registered signed overflow flag (ADD/SUB only)
module alu_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  ALUCtrl_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        overflow_o
);

  localparam int unsigned W   = 32;
  localparam int unsigned OPW = 4;
  localparam int unsigned CW  = 5;

  localparam logic [OPW-1:0] OP_AND = 4'b0000;
  localparam logic [OPW-1:0] OP_OR  = 4'b0001;
  localparam logic [OPW-1:0] OP_ADD = 4'b0010;
  localparam logic [OPW-1:0] OP_SUB = 4'b0110;
  localparam logic [OPW-1:0] OP_SLT = 4'b0111;
  localparam logic [OPW-1:0] OP_NOR = 4'b1100;
  localparam logic [OPW-1:0] OP_MUL = 4'b1000;

  localparam logic [CW-1:0] CNT_LAST = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q, state_nxt;
  logic [OPW-1:0] op_q, op_nxt;
  logic [W-1:0]   a_q, a_nxt;
  logic [W-1:0]   b_q, b_nxt;
  logic [W-1:0]   acc_q, acc_nxt;
  logic [CW-1:0]  cnt_q, cnt_nxt;
  logic [W-1:0]   result_nxt;
  logic           zero_nxt;
  logic           overflow_nxt;
  logic           busy_nxt;
  logic           done_nxt;

  logic [W:0]     alu_c;
  logic [W-1:0]   term_c;
  logic [W-1:0]   prod_c;

  // Single-cycle ops; returns {overflow, result}. Unknown codes give zero.
  function automatic logic [W:0] alu_op(input logic [OPW-1:0] op,
                                        input logic [W-1:0]   a,
                                        input logic [W-1:0]   b);
    logic [W-1:0] r;
    logic         v;
    r = '0;
    v = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOR: r = ~(a | b);
      OP_ADD: begin
        r = a + b;
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_SUB: begin
        r = a - b;
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      // Direct signed compare, so an overflowing difference cannot flip it.
      OP_SLT: r = ($signed(a) < $signed(b)) ? W'(1) : '0;
      default: r = '0;
    endcase
    return {v, r};
  endfunction

  assign alu_c  = alu_op(ALUCtrl_i, src1_i, src2_i);
  // One multiplier bit per iteration, LSB first.
  assign term_c = b_q[cnt_q] ? (a_q << cnt_q) : '0;
  assign prod_c = acc_q + term_c;

  // Next-state and datapath next values.
  always_comb begin
    state_nxt    = state_q;
    op_nxt       = op_q;
    a_nxt        = a_q;
    b_nxt        = b_q;
    acc_nxt      = acc_q;
    cnt_nxt      = cnt_q;
    result_nxt   = result_o;
    zero_nxt     = zero_o;
    overflow_nxt = overflow_o;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_nxt = ALUCtrl_i;
          a_nxt  = src1_i;
          b_nxt  = src2_i;
          if (ALUCtrl_i == OP_MUL) begin
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = ST_MUL;
          end else begin
            result_nxt   = alu_c[W-1:0];
            zero_nxt     = (alu_c[W-1:0] == '0);
            overflow_nxt = alu_c[W];
            state_nxt    = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        acc_nxt = prod_c;
        cnt_nxt = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          result_nxt   = prod_c;
          zero_nxt     = (prod_c == '0);
          overflow_nxt = 1'b0;
          state_nxt    = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_o   <= '0;
      zero_o     <= 1'b1;
      overflow_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      op_q       <= op_nxt;
      a_q        <= a_nxt;
      b_q        <= b_nxt;
      acc_q      <= acc_nxt;
      cnt_q      <= cnt_nxt;
      result_o   <= result_nxt;
      zero_o     <= zero_nxt;
      overflow_o <= overflow_nxt;
      busy_o     <= busy_nxt;
      done_o     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed plus randomized checks of alu_seq against an
// arithmetic reference model.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        ovf;

  int checks;
  int failures;

  logic [31:0] last_res;
  logic        last_zero;
  logic        last_ovf;

  alu_seq dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .start_i    (start),
    .ALUCtrl_i  (ctrl),
    .src1_i     (src1),
    .src2_i     (src2),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result),
    .zero_o     (zero),
    .overflow_o (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, result} from plain arithmetic on the operation.
  function automatic logic [32:0] ref_model(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, s;
    logic [63:0] p;
    logic [31:0] r;
    logic        v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 32'd0;
    v  = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        s = sa + sb;
        r = 32'(s);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = sa - sb;
        r = 32'(s);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0];
      end
      default: r = 32'd0;
    endcase
    return {v, r};
  endfunction

  // Issue one op and check latency, result flags and return to idle.
  // With hold set, start stays high with fresh random inputs while busy.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit hold);
    logic [32:0] exp;
    int          lat;
    int          n;
    exp = ref_model(op, a, b);
    lat = (op == 4'b1000) ? 33 : 1;
    @(negedge clk);
    start = 1'b1;
    ctrl  = op;
    src1  = a;
    src2  = b;
    @(negedge clk);
    n = 1;
    if (!hold) start = 1'b0;
    while (!done && n < 40) begin
      if (n == 16) check("hold_during_op", result, last_res);
      if (hold) begin
        ctrl = 4'($urandom_range(0, 15));
        src1 = $urandom;
        src2 = $urandom;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check($sformatf("latency op=%b", op), 32'(n), 32'(lat));
    check($sformatf("busy_at_done op=%b", op), 32'(busy), 32'd1);
    check($sformatf("result op=%b a=%h b=%h", op, a, b), result, exp[31:0]);
    check($sformatf("zero op=%b", op), 32'(zero), 32'(exp[31:0] == 32'd0));
    check($sformatf("ovf op=%b", op), 32'(ovf), 32'(exp[32]));
    last_res  = exp[31:0];
    last_zero = (exp[31:0] == 32'd0);
    last_ovf  = exp[32];
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("done_after", 32'(done), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] ops [8];
    logic [3:0] op;
    checks   = 0;
    failures = 0;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b1111};
    rst_n = 1'b0;
    start = 1'b0;
    ctrl  = 4'd0;
    src1  = 32'd0;
    src2  = 32'd0;
    last_res  = 32'd0;
    last_zero = 1'b1;
    last_ovf  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    // Directed corner cases.
    do_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    do_op(4'b0110, 32'd5, 32'd5, 1'b0);
    do_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    do_op(4'b0111, 32'h8000_0000, 32'h0000_0001, 1'b0);
    do_op(4'b0110, 32'h8000_0000, 32'h0000_0001, 1'b0);
    do_op(4'b1000, 32'h0001_2345, 32'h0000_0100, 1'b0);
    do_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(4'b1000, 32'h0000_0000, 32'h1234_5678, 1'b0);
    do_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    do_op(4'b1000, 32'h0000_0007, 32'h0000_0009, 1'b1);

    // Outputs hold while idle with start low and inputs moving.
    for (int i = 0; i < 4; i++) begin
      ctrl = 4'($urandom_range(0, 15));
      src1 = $urandom;
      src2 = $urandom;
      @(negedge clk);
      check("idle_hold_result", result, last_res);
      check("idle_hold_zero", 32'(zero), 32'(last_zero));
      check("idle_hold_ovf", 32'(ovf), 32'(last_ovf));
    end

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1;
    ctrl  = 4'b1000;
    src1  = 32'h0000_1234;
    src2  = 32'h0000_5678;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_zero", 32'(zero), 32'd1);
    check("arst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = 32'd0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) check("no_done_after_reset", {30'd0, busy, done}, 32'd0);
    end
    check("post_reset_idle", {30'd0, busy, done}, 32'd0);
    do_op(4'b0010, 32'd2, 32'd3, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(0, 15));
      else op = ops[$urandom_range(0, 7)];
      do_op(op, pick_operand(), pick_operand(), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 rst_i  input  1  reset, asynchronous, active-low; asserted (0) clears all state immediately, independent of clk_i.
REQ-003 start_i  input  1  operation request; sampled only on an edge where busy_o=0.
REQ-004 ALUCtrl_i  input  4  operation code, same encoding the ALU control stage drives: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MUL.
REQ-005 src1_i  input  32  operand A.
REQ-006 src2_i  input  32  operand B.
REQ-007 busy_o  output  1  1 while an accepted operation is in progress or completing.
REQ-008 done_o  output  1  single-cycle completion pulse.
REQ-009 result_o  output  32  registered result.
REQ-010 zero_o  output  1  registered flag, 1 when result_o == 0.
REQ-011 overflow_o  output  1  registered signed-overflow flag for ADD/SUB.

Function
REQ-012 The block SHALL implement FSM states IDLE, MUL, DONE; busy_o = (state != IDLE); done_o = (state == DONE).
REQ-013 IDLE, start_i=1: SHALL latch ALUCtrl_i, src1_i, src2_i; non-MUL code -> compute, write result_o/zero_o/overflow_o on that edge, go DONE; MUL -> clear accumulator, counter=0, go MUL.
REQ-014 IDLE, start_i=0: SHALL stay IDLE; outputs hold.
REQ-015 start_i while busy_o=1 SHALL be ignored; latched operands/code SHALL not change until IDLE.
REQ-016 Non-MUL latency: done_o SHALL be high exactly in the cycle following the accepting edge.
REQ-017 MUL: unsigned shift-add, one multiplier bit per cycle LSB-first, 32 iterations; counter 5 bits, last iteration at counter==31 writes result_o = low 32 bits of product, goes DONE; done_o SHALL be high in the 33rd cycle after the accepting edge.
REQ-018 DONE SHALL last one cycle then return to IDLE unconditionally; start_i in DONE ignored; earliest next accept is the edge leaving IDLE's first cycle.
REQ-019 ADD/SUB SHALL wrap modulo 2^32; overflow_o = signed overflow of that op; overflow_o = 0 for all other codes.
REQ-020 SLT SHALL compare signed, result_o = 32'd1 if src1 < src2 else 32'd0; correct across overflowing differences (e.g. 0x80000000 vs 0x00000001 -> 1).
REQ-021 NOR SHALL give ~(src1|src2); AND/OR bitwise.
REQ-022 Undefined codes SHALL complete as non-MUL ops with result_o=0, zero_o=1, overflow_o=0.
REQ-023 result_o, zero_o, overflow_o SHALL change only on completion writes and SHALL hold between operations.
REQ-024 MUL with either operand 0 SHALL still take full 32 iterations (fixed latency).

Reset
REQ-025 rst_i=0 SHALL force state IDLE, busy_o=0, done_o=0, result_o=0, zero_o=1, overflow_o=0, counter/accumulator/latched operands=0.
REQ-026 Reset during MUL or DONE SHALL abort with no done_o pulse; first accept SHALL occur on the first rising edge with rst_i=1 and start_i=1.

Verification
REQ-027 ADD 0x7FFFFFFF + 0x00000001, start one cycle -> next cycle done_o=1, result_o=0x80000000, overflow_o=1, zero_o=0, busy_o=1; following cycle busy_o=0.
REQ-028 SUB 5-5 -> result_o=0, zero_o=1, overflow_o=0; SLT 0xFFFFFFFF vs 0x00000001 -> result_o=1.
REQ-029 MUL 0x00012345 * 0x00000100 -> done_o in cycle 33 after accept, result_o=0x01234500; MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
REQ-030 start_i held high with new operands throughout a MUL -> ignored; result equals first operands; next op accepted only after returning IDLE.
REQ-031 rst_i pulsed low at iteration 10 of MUL, asynchronous to clk_i -> outputs immediately at reset values, no done_o; subsequent ADD 2+3 gives result_o=5 with normal 1-cycle latency.
REQ-032 ALUCtrl_i=1111 -> done_o next cycle, result_o=0, zero_o=1.
